// File: rtl/bram_rd_pkg.sv
// ---------------------------------------------------------------------------
// bram_rd_pkg
// Shared definitions for the TDP36K streaming reader:
//   MODE_*       port-width mode codes, shared with the BRAM techmap
//   rd_state_e   reader FSM states
//   width_legal  true for logical widths a TDP36K half-port supports
//   width_shift  logical-to-hardware address shift for a logical width
//   unpack       extracts a logical word from the 18-bit parity layout
// ---------------------------------------------------------------------------
package bram_rd_pkg;

    localparam logic [2:0] MODE_1  = 3'b101;
    localparam logic [2:0] MODE_2  = 3'b110;
    localparam logic [2:0] MODE_4  = 3'b100;
    localparam logic [2:0] MODE_9  = 3'b001;
    localparam logic [2:0] MODE_18 = 3'b010;
    localparam logic [2:0] MODE_36 = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rd_state_e;

    function automatic bit width_legal(input int data_width);
        case (data_width)
            1, 2, 4, 8, 9, 16, 18: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic int width_shift(input int data_width);
        case (data_width)
            1:       return 0;
            2:       return 1;
            4:       return 2;
            8, 9:    return 3;
            16, 18:  return 4;
            default: return 0;
        endcase
    endfunction

    // Width 9 keeps its ninth bit in the parity lane (bit 16), so it is
    // gathered next to the byte; every other width sits in the low bits.
    function automatic logic [17:0] unpack(input logic [17:0] rdata, input int data_width);
        logic [17:0] mask;
        if (data_width == 9) begin
            return {9'd0, rdata[16], rdata[7:0]};
        end
        mask = (18'd1 << data_width) - 18'd1;
        return rdata & mask;
    endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// ---------------------------------------------------------------------------
// bram_rd_fifo
// Four-entry output buffer of {last, data}. The head entry drives the stream
// directly from registers; push and pop may occur in the same cycle.
//   clk_i, rst_ni   clock, synchronous active-low reset
//   flush_i         empties the buffer (stored words are dropped)
//   push_i/_data_i  write one entry
//   pop_i           consume the head entry
//   head_data_o     head entry {last, data}
//   head_valid_o    buffer not empty
//   count_o         occupancy, 0..4
// ---------------------------------------------------------------------------
module bram_rd_fifo #(
    parameter int unsigned WIDTH = 19
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             head_valid_o,
    output logic [2:0]       count_o
);

    localparam int unsigned DEPTH = 4;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_i && (count_q != 3'd0);
    assign push_ok = push_i && ((count_q != 3'(DEPTH)) || pop_ok);

    // NOTE: non-blocking assignments throughout, so every register here
    // updates from values sampled before the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            // NOTE: the storage is reset too, so the stream data reads zero
            // after reset instead of stale or unknown contents.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_data_o  = mem_q[rd_ptr_q];
    assign head_valid_o = (count_q != 3'd0);
    assign count_o      = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
// Walks a contiguous logical-address range of one TDP36K read port and
// streams the words out on a valid/ready interface.
//   CLK_i, RESET_N_i       clock, synchronous active-low reset
//   START_i, BASE_ADDR_i,
//   LENGTH_i               transfer command (sampled together)
//   ABORT_i                cancel the current transfer
//   BUSY_o, DONE_o         transfer in progress / normal completion pulse
//   TDATA_o, TVALID_o,
//   TREADY_i, TLAST_o      output stream
//   BRAM_ADDR_o,
//   BRAM_REN_o,
//   BRAM_RDATA_i           TDP36K read port (1-cycle registered read)
// ---------------------------------------------------------------------------
module bram_stream_reader
    import bram_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  CLK_i,
    input  logic                  RESET_N_i,
    input  logic                  START_i,
    input  logic [ADDR_WIDTH-1:0] BASE_ADDR_i,
    input  logic [ADDR_WIDTH:0]   LENGTH_i,
    input  logic                  ABORT_i,
    output logic                  BUSY_o,
    output logic                  DONE_o,
    output logic [DATA_WIDTH-1:0] TDATA_o,
    output logic                  TVALID_o,
    input  logic                  TREADY_i,
    output logic                  TLAST_o,
    output logic [13:0]           BRAM_ADDR_o,
    output logic                  BRAM_REN_o,
    input  logic [17:0]           BRAM_RDATA_i
);

    localparam int SHIFT = width_shift(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE = (ADDR_WIDTH+1)'(1);

    if (!width_legal(DATA_WIDTH)) begin : g_bad_width
        $error("bram_stream_reader: unsupported DATA_WIDTH %0d", DATA_WIDTH);
    end
    if (ADDR_WIDTH > 14 - SHIFT) begin : g_bad_addr
        $error("bram_stream_reader: ADDR_WIDTH %0d too wide for DATA_WIDTH %0d",
               ADDR_WIDTH, DATA_WIDTH);
    end

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // last issued address
    logic [ADDR_WIDTH:0]   length_q, length_d;
    logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
    logic                  ren_q, ren_d;            // read presented this cycle
    logic                  ren_last_q, ren_last_d;  // ... and it is word LENGTH-1
    logic                  rd_valid_q, rd_valid_d;  // RDATA valid this cycle
    logic                  rd_last_q, rd_last_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH:0]   head_data;
    logic                  head_valid;
    logic [2:0]            fifo_count;
    logic                  pop;
    logic                  last_accept;
    logic                  credit_ok;
    logic [2:0]            outstanding;

    assign pop         = head_valid && TREADY_i;
    assign last_accept = pop && head_data[DATA_WIDTH];

    // Buffered words plus reads still on their way must leave a free slot
    // for a new read; this bounds the buffer without ever stalling a read.
    assign outstanding = fifo_count + {2'b00, ren_q} + {2'b00, rd_valid_q};
    assign credit_ok   = (outstanding < 3'd4);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        length_d    = length_q;
        issue_cnt_d = issue_cnt_q;
        ren_d       = 1'b0;
        ren_last_d  = 1'b0;
        done_d      = 1'b0;
        rd_valid_d  = ren_q && !ABORT_i;
        rd_last_d   = ren_last_q;

        if (ABORT_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START_i) begin
                        if (LENGTH_i == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d     = RUN;
                            addr_d      = BASE_ADDR_i;
                            length_d    = LENGTH_i;
                            issue_cnt_d = LEN_ONE;
                            ren_d       = 1'b1;
                            ren_last_d  = (LENGTH_i == LEN_ONE);
                        end
                    end
                end
                RUN: begin
                    if (issue_cnt_q == length_q) begin
                        state_d = DRAIN;
                    end else if (credit_ok) begin
                        ren_d       = 1'b1;
                        addr_d      = addr_q + 1'b1;
                        issue_cnt_d = issue_cnt_q + LEN_ONE;
                        ren_last_d  = (issue_cnt_d == length_q);
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_i) begin
        if (!RESET_N_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            length_q    <= '0;
            issue_cnt_q <= '0;
            ren_q       <= 1'b0;
            ren_last_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            length_q    <= length_d;
            issue_cnt_q <= issue_cnt_d;
            ren_q       <= ren_d;
            ren_last_q  <= ren_last_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    bram_rd_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i       (CLK_i),
        .rst_ni      (RESET_N_i),
        .flush_i     (ABORT_i),
        .push_i      (rd_valid_q),
        .push_data_i ({rd_last_q, DATA_WIDTH'(unpack(BRAM_RDATA_i, DATA_WIDTH))}),
        .pop_i       (pop),
        .head_data_o (head_data),
        .head_valid_o(head_valid),
        .count_o     (fifo_count)
    );

    assign BUSY_o      = (state_q != IDLE);
    assign DONE_o      = done_q;
    assign BRAM_REN_o  = ren_q;
    assign BRAM_ADDR_o = 14'(addr_q) << SHIFT;
    assign TDATA_o     = head_data[DATA_WIDTH-1:0];
    assign TVALID_o    = head_valid;
    assign TLAST_o     = head_valid && head_data[DATA_WIDTH];

endmodule

// File: tb/tb_bram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_bram_stream_reader
// Directed bench for two reader instances: A (18-bit words, 10-bit address)
// and B (9-bit words, 4-bit address), each attached to a behavioural TDP36K
// read port with one cycle of registered read latency.
// Cycle numbering: cycle 0 is the cycle in which START_i is held high.
// ---------------------------------------------------------------------------
module tb_bram_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: DATA_WIDTH 18, ADDR_WIDTH 10
    logic        start_a, abort_a, tready_a;
    logic [9:0]  base_a;
    logic [10:0] len_a;
    logic        busy_a, done_a, tvalid_a, tlast_a, ren_a;
    logic [17:0] tdata_a, rdata_a;
    logic [13:0] addr_a;

    // Instance B: DATA_WIDTH 9, ADDR_WIDTH 4
    logic        start_b, abort_b, tready_b;
    logic [3:0]  base_b;
    logic [4:0]  len_b;
    logic        busy_b, done_b, tvalid_b, tlast_b, ren_b;
    logic [8:0]  tdata_b;
    logic [17:0] rdata_b;
    logic [13:0] addr_b;

    bram_stream_reader #(.DATA_WIDTH(18), .ADDR_WIDTH(10)) dut_a (
        .CLK_i(clk), .RESET_N_i(rst_n), .START_i(start_a), .BASE_ADDR_i(base_a),
        .LENGTH_i(len_a), .ABORT_i(abort_a), .BUSY_o(busy_a), .DONE_o(done_a),
        .TDATA_o(tdata_a), .TVALID_o(tvalid_a), .TREADY_i(tready_a), .TLAST_o(tlast_a),
        .BRAM_ADDR_o(addr_a), .BRAM_REN_o(ren_a), .BRAM_RDATA_i(rdata_a)
    );

    bram_stream_reader #(.DATA_WIDTH(9), .ADDR_WIDTH(4)) dut_b (
        .CLK_i(clk), .RESET_N_i(rst_n), .START_i(start_b), .BASE_ADDR_i(base_b),
        .LENGTH_i(len_b), .ABORT_i(abort_b), .BUSY_o(busy_b), .DONE_o(done_b),
        .TDATA_o(tdata_b), .TVALID_o(tvalid_b), .TREADY_i(tready_b), .TLAST_o(tlast_b),
        .BRAM_ADDR_o(addr_b), .BRAM_REN_o(ren_b), .BRAM_RDATA_i(rdata_b)
    );

    // Behavioural TDP36K read ports. A: memory[i] = i at 16-bit granularity.
    // B: 9-bit layout with bit16 set, filler in the unused lanes, and the
    // byte lane holding 0xA5 ^ i.
    logic [17:0] mem_a [0:1023];
    logic [17:0] mem_b [0:2047];

    always @(posedge clk) if (ren_a) rdata_a <= mem_a[addr_a[13:4]];
    always @(posedge clk) if (ren_b) rdata_b <= mem_b[addr_b[13:3]];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          issued;
    int          accepted;
    logic        hold_valid;
    logic [17:0] hold_data;

    initial begin
        for (int i = 0; i < 1024; i++) mem_a[i] = 18'(i);
        for (int i = 0; i < 2048; i++) mem_b[i] = {2'b11, 8'h3C, 8'hA5 ^ 8'(i)};
        rdata_a = '0;
        rdata_b = '0;

        rst_n = 1'b0;
        start_a = 0; abort_a = 0; tready_a = 1; base_a = '0; len_a = '0;
        start_b = 0; abort_b = 0; tready_b = 1; base_b = '0; len_b = '0;
        repeat (3) tick();

        // Reset state
        check("rst_tvalid", tvalid_a, 0);
        check("rst_tdata",  tdata_a, 0);
        check("rst_tlast",  tlast_a, 0);
        check("rst_ren",    ren_a, 0);
        check("rst_addr",   addr_a, 0);
        check("rst_busy",   busy_a, 0);
        check("rst_done",   done_a, 0);
        rst_n = 1'b1;
        tick();

        // Base 5, length 4, TREADY high
        start_a = 1; base_a = 10'd5; len_a = 11'd4;
        tick(); start_a = 0;                                   // cycle 1
        check("t1_c1_ren", ren_a, 1);   check("t1_c1_addr", addr_a, 80);
        check("t1_c1_busy", busy_a, 1); check("t1_c1_tvalid", tvalid_a, 0);
        tick();                                                // cycle 2
        check("t1_c2_ren", ren_a, 1);   check("t1_c2_addr", addr_a, 96);
        check("t1_c2_tvalid", tvalid_a, 0);
        tick();                                                // cycle 3
        check("t1_c3_addr", addr_a, 112);
        check("t1_c3_tvalid", tvalid_a, 1); check("t1_c3_tdata", tdata_a, 5);
        check("t1_c3_tlast", tlast_a, 0);
        tick();                                                // cycle 4
        check("t1_c4_ren", ren_a, 1);   check("t1_c4_addr", addr_a, 128);
        check("t1_c4_tdata", tdata_a, 6);
        tick();                                                // cycle 5
        check("t1_c5_ren", ren_a, 0);   check("t1_c5_tdata", tdata_a, 7);
        check("t1_c5_tlast", tlast_a, 0);
        tick();                                                // cycle 6
        check("t1_c6_tdata", tdata_a, 8); check("t1_c6_tlast", tlast_a, 1);
        check("t1_c6_done", done_a, 0);
        tick();                                                // cycle 7
        check("t1_c7_done", done_a, 1); check("t1_c7_busy", busy_a, 0);
        check("t1_c7_tvalid", tvalid_a, 0);
        tick();
        check("t1_c8_done", done_a, 0);

        // Width 9 unpack: address 0 holds bit16=1, byte 0xA5
        start_b = 1; base_b = 4'd0; len_b = 5'd1;
        tick(); start_b = 0;
        check("w9_c1_ren", ren_b, 1); check("w9_c1_addr", addr_b, 0);
        tick(); tick();
        check("w9_c3_tvalid", tvalid_b, 1); check("w9_c3_tdata", tdata_b, 9'h1A5);
        check("w9_c3_tlast", tlast_b, 1);
        tick();
        check("w9_c4_done", done_b, 1);

        // Address wrap: base 14, length 4 on a 4-bit address space
        start_b = 1; base_b = 4'd14; len_b = 5'd4;
        tick(); start_b = 0;
        check("wr_c1_addr", addr_b, 112);
        tick(); check("wr_c2_addr", addr_b, 120);
        tick(); check("wr_c3_addr", addr_b, 0);   check("wr_c3_tdata", tdata_b, 9'h1AB);
        tick(); check("wr_c4_addr", addr_b, 8);   check("wr_c4_tdata", tdata_b, 9'h1AA);
        tick(); check("wr_c5_tdata", tdata_b, 9'h1A5); check("wr_c5_tlast", tlast_b, 0);
        tick(); check("wr_c6_tdata", tdata_b, 9'h1A4); check("wr_c6_tlast", tlast_b, 1);
        tick(); check("wr_c7_done", done_b, 1);

        // Backpressure: base 100, length 16, random TREADY
        start_a = 1; base_a = 10'd100; len_a = 11'd16;
        tick(); start_a = 0;
        issued = 0; accepted = 0; hold_valid = 0; hold_data = '0;
        for (int cyc = 0; cyc < 400 && accepted < 16; cyc++) begin
            tready_a = 1'($urandom_range(0, 1));
            if (hold_valid) begin
                check("bp_hold_valid", tvalid_a, 1);
                check("bp_hold_data", tdata_a, hold_data);
            end
            if (ren_a) begin
                check("bp_addr", addr_a, 32'((100 + issued) * 16));
                issued++;
            end
            check("bp_credit", 32'(issued - accepted <= 4), 1);
            hold_valid = tvalid_a && !tready_a;
            hold_data  = tdata_a;
            if (tvalid_a && tready_a) begin
                check("bp_tdata", tdata_a, 32'(100 + accepted));
                check("bp_tlast", tlast_a, 32'(accepted == 15));
                accepted++;
            end
            if (accepted < 16) tick();
        end
        check("bp_accepted", accepted, 16);
        tick();
        check("bp_issued", issued, 16);
        check("bp_done", done_a, 1);
        tready_a = 1;
        tick();

        // Abort in cycle 4 of a 10-word transfer
        start_a = 1; base_a = 10'd200; len_a = 11'd10;
        tick(); start_a = 0;
        tick(); tick(); tick();                                // cycle 4
        check("ab_c4_tdata", tdata_a, 201);
        abort_a = 1;
        tick(); abort_a = 0;                                   // cycle 5
        check("ab_c5_tvalid", tvalid_a, 0); check("ab_c5_ren", ren_a, 0);
        check("ab_c5_busy", busy_a, 0);
        for (int i = 0; i < 4; i++) begin
            check("ab_no_done", done_a, 0);
            check("ab_no_tvalid", tvalid_a, 0);
            tick();
        end
        start_a = 1; base_a = 10'd7; len_a = 11'd2;
        tick(); start_a = 0;
        tick(); tick();
        check("ab_re_tdata0", tdata_a, 7); check("ab_re_tvalid", tvalid_a, 1);
        tick();
        check("ab_re_tdata1", tdata_a, 8); check("ab_re_tlast", tlast_a, 1);
        tick();
        check("ab_re_done", done_a, 1);
        tick();

        // START and ABORT together in IDLE: abort wins
        start_a = 1; abort_a = 1; base_a = 10'd3; len_a = 11'd2;
        tick(); start_a = 0; abort_a = 0;
        check("sa_ren", ren_a, 0); check("sa_busy", busy_a, 0);
        tick();
        check("sa_done", done_a, 0); check("sa_tvalid", tvalid_a, 0);

        // LENGTH 0: DONE next cycle, no read
        start_a = 1; base_a = 10'd9; len_a = 11'd0;
        tick(); start_a = 0;
        check("l0_done", done_a, 1); check("l0_ren", ren_a, 0);
        check("l0_busy", busy_a, 0);
        tick();
        check("l0_done_off", done_a, 0);

        // Reset mid-transfer
        start_a = 1; base_a = 10'd5; len_a = 11'd4;
        tick(); start_a = 0;
        tick(); tick();                                        // cycle 3
        check("mr_c3_tvalid", tvalid_a, 1);
        rst_n = 1'b0;
        tick();
        check("mr_tvalid", tvalid_a, 0); check("mr_tdata", tdata_a, 0);
        check("mr_tlast", tlast_a, 0);   check("mr_ren", ren_a, 0);
        check("mr_addr", addr_a, 0);     check("mr_busy", busy_a, 0);
        check("mr_done", done_a, 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
